// File: rtl/axis_coincidence_pkg.sv
// Shared types for the detector coincidence reader: FSM state encoding and the
// popcount width helper.
package axis_coincidence_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_OR    = 3'd2,
    ST_SUM   = 3'd3,
    ST_CMP   = 3'd4,
    ST_SEND  = 3'd5,
    ST_DEAD  = 3'd6
  } state_e;

  // Bits needed to hold a count of 0..n without overflow.
  function automatic int unsigned pop_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/coincidence_popcount.sv
// Combinational per-group OR of the accumulated hit word, and popcount of the
// registered group-hit vector.
module coincidence_popcount
  import axis_coincidence_pkg::*;
#(
  parameter int unsigned GROUP_WIDTH = 16,
  parameter int unsigned GROUP_COUNT = 4
) (
  input  logic [GROUP_WIDTH*GROUP_COUNT-1:0] acc,
  input  logic [GROUP_COUNT-1:0]             hit,
  output logic [GROUP_COUNT-1:0]             hit_c,
  output logic [pop_width(GROUP_COUNT)-1:0]  sum_c
);

  localparam int unsigned SW = pop_width(GROUP_COUNT);

  always_comb begin
    hit_c = '0;
    for (int unsigned g = 0; g < GROUP_COUNT; g++) begin
      hit_c[g] = |acc[g*GROUP_WIDTH +: GROUP_WIDTH];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned g = 0; g < GROUP_COUNT; g++) begin
      sum_c = sum_c + SW'(hit[g]);
    end
  end

endmodule

// File: rtl/axis_coincidence_reader.sv
// Detector coincidence reader: delays hits, ORs them over a window, and emits one
// AXI4-Stream event when enough groups fired. AXIS_COINCIDENCE_READER_LOST_EN enables sts_lost.
module axis_coincidence_reader
  import axis_coincidence_pkg::*;
#(
  parameter int unsigned GROUP_WIDTH  = 16,
  parameter int unsigned GROUP_COUNT  = 4,
  parameter int unsigned DELAY        = 5,
  parameter int unsigned WINDOW_WIDTH = 4,
  parameter int unsigned DEAD_WIDTH   = 16,
  parameter int unsigned TIME_WIDTH   = 64
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [GROUP_WIDTH*GROUP_COUNT-1:0]       det_data,
  input  logic [WINDOW_WIDTH-1:0]                  cfg_window,
  input  logic [pop_width(GROUP_COUNT)-1:0]        cfg_thresh,
  input  logic [DEAD_WIDTH-1:0]                    cfg_dead,
  output logic [31:0]                              sts_lost,
  input  logic                                     m_axis_tready,
  output logic [TIME_WIDTH+GROUP_WIDTH*GROUP_COUNT-1:0] m_axis_tdata,
  output logic                                     m_axis_tvalid
);

  localparam int unsigned DW = GROUP_WIDTH * GROUP_COUNT;
  localparam int unsigned SW = pop_width(GROUP_COUNT);

  logic [DW-1:0] pipe_q [DELAY];
  logic [DW-1:0] pipe_d [DELAY];
  logic [DW-1:0] tap;

  state_e                  state_q, state_d;
  logic [DW-1:0]           acc_q, acc_d;
  logic [TIME_WIDTH-1:0]   ts_q, ts_d;
  logic [TIME_WIDTH-1:0]   time_q, time_d;
  logic [WINDOW_WIDTH-1:0] win_q, win_d;
  logic [WINDOW_WIDTH-1:0] cntr_q, cntr_d;
  logic [GROUP_COUNT-1:0]  hit_q, hit_d, hit_c;
  logic [SW-1:0]           sum_q, sum_d, sum_c;
  logic [DEAD_WIDTH-1:0]   dcnt_q, dcnt_d;
  logic                    tvalid_q, tvalid_d;

  // Detector delay line; the tap is the last stage.
  always_comb begin
    pipe_d[0] = det_data;
    for (int unsigned k = 1; k < DELAY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge aclk) begin
    for (int unsigned k = 0; k < DELAY; k++) begin
      pipe_q[k] <= aresetn ? pipe_d[k] : '0;
    end
  end

  assign tap = pipe_q[DELAY-1];

  coincidence_popcount #(
    .GROUP_WIDTH (GROUP_WIDTH),
    .GROUP_COUNT (GROUP_COUNT)
  ) u_popcount (
    .acc   (acc_q),
    .hit   (hit_q),
    .hit_c (hit_c),
    .sum_c (sum_c)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ts_d     = ts_q;
    win_d    = win_q;
    cntr_d   = cntr_q;
    hit_d    = hit_q;
    sum_d    = sum_q;
    dcnt_d   = dcnt_q;
    tvalid_d = tvalid_q;
    time_d   = time_q + TIME_WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (tap != '0) begin
          acc_d   = tap;
          ts_d    = time_q;
          win_d   = cfg_window;
          cntr_d  = '0;
          state_d = (cfg_window != '0) ? ST_ACCUM : ST_OR;
        end
      end
      ST_ACCUM: begin
        acc_d  = acc_q | tap;
        cntr_d = cntr_q + WINDOW_WIDTH'(1);
        if (cntr_q == win_q - WINDOW_WIDTH'(1)) state_d = ST_OR;
      end
      ST_OR: begin
        hit_d   = hit_c;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        sum_d   = sum_c;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        if (sum_q >= cfg_thresh) begin
          tvalid_d = 1'b1;
          state_d  = ST_SEND;
        end else if (cfg_dead != '0) begin
          dcnt_d  = cfg_dead - DEAD_WIDTH'(1);
          state_d = ST_DEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          if (cfg_dead != '0) begin
            dcnt_d  = cfg_dead - DEAD_WIDTH'(1);
            state_d = ST_DEAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DEAD: begin
        if (dcnt_q == '0) state_d = ST_IDLE;
        else              dcnt_d  = dcnt_q - DEAD_WIDTH'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      ts_q     <= '0;
      time_q   <= '0;
      win_q    <= '0;
      cntr_q   <= '0;
      hit_q    <= '0;
      sum_q    <= '0;
      dcnt_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ts_q     <= ts_d;
      time_q   <= time_d;
      win_q    <= win_d;
      cntr_q   <= cntr_d;
      hit_q    <= hit_d;
      sum_q    <= sum_d;
      dcnt_q   <= dcnt_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = {ts_q, acc_q};

`ifdef AXIS_COINCIDENCE_READER_LOST_EN
  // Tap activity that arrives while an event is being processed is counted as lost.
  logic [31:0] lost_q, lost_d;
  logic        blocked;

  always_comb begin
    lost_d  = lost_q;
    blocked = (state_q != ST_IDLE) && (state_q != ST_ACCUM);
    if (blocked && (tap != '0) && (lost_q != '1)) lost_d = lost_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) lost_q <= '0;
    else          lost_q <= lost_d;
  end

  assign sts_lost = lost_q;
`else
  assign sts_lost = '0;
`endif

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed bench for axis_coincidence_reader with an expected-event scoreboard.
// Cycle n is the cycle in which the DUT time counter holds n.
module tb_axis_coincidence_reader;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 64;
  localparam int unsigned OW = TW + DW;
`ifdef AXIS_COINCIDENCE_READER_LOST_EN
  localparam bit LOST_ON = 1'b1;
`else
  localparam bit LOST_ON = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] det_data = '0;
  logic [3:0]    cfg_window = '0;
  logic [2:0]    cfg_thresh = 3'd2;
  logic [15:0]   cfg_dead = '0;
  logic [31:0]   sts_lost;
  logic          m_axis_tready = 1'b1;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [OW-1:0] exp_q[$];

  axis_coincidence_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .det_data      (det_data),
    .cfg_window    (cfg_window),
    .cfg_thresh    (cfg_thresh),
    .cfg_dead      (cfg_dead),
    .sts_lost      (sts_lost),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one cycle; scoreboard handshakes before the edge, hold checks after it.
  task automatic tick();
    logic hs;
    logic hold;
    hs   = aresetn && m_axis_tvalid && m_axis_tready;
    hold = aresetn && m_axis_tvalid && !m_axis_tready;
    if (hs) begin
      if (exp_q.size() == 0) check("spurious_tvalid", OW'(m_axis_tvalid), OW'(0));
      else                   check("event_data", m_axis_tdata, exp_q.pop_front());
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (hold && aresetn) begin
      check("hold_tvalid", OW'(m_axis_tvalid), OW'(1));
      if (exp_q.size() != 0) check("hold_tdata", m_axis_tdata, exp_q[0]);
      else                   check("hold_spurious", OW'(m_axis_tvalid), OW'(0));
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse(input int c, input logic [DW-1:0] v);
    run_to(c);
    det_data = v;
    tick();
    det_data = '0;
  endtask

  task automatic do_reset(input int n);
    aresetn  = 1'b0;
    det_data = '0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    // Basic event, two groups, threshold 2
    do_reset(3);
    check("rst_tvalid", OW'(m_axis_tvalid), OW'(0));
    check("rst_tdata", m_axis_tdata, OW'(0));
    check("rst_lost", OW'(sts_lost), OW'(0));
    exp_q.push_back({64'd15, 64'h0001_0000_0000_0001});
    pulse(10, 64'h0001_0000_0000_0001);
    run_to(18); check("t1_pre", OW'(m_axis_tvalid), OW'(0));
    run_to(19); check("t1_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(20); check("t1_single", OW'(m_axis_tvalid), OW'(0));
    check("t1_drained", OW'(exp_q.size()), OW'(0));

    // Window of 4 samples; a hit one sample late is excluded
    do_reset(2);
    cfg_window = 4'd3;
    exp_q.push_back({64'd15, 64'h0000_0000_0001_0001});
    pulse(10, 64'h1);
    pulse(13, 64'h1_0000);
    pulse(14, 64'h1_0000_0000);
    run_to(21); check("t2_pre", OW'(m_axis_tvalid), OW'(0));
    run_to(22); check("t2_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(25); check("t2_lost", OW'(sts_lost), OW'(LOST_ON ? 1 : 0));
    check("t2_drained", OW'(exp_q.size()), OW'(0));

    // Threshold 3 with two groups never fires; threshold 0 with one channel fires
    do_reset(2);
    cfg_window = 4'd0;
    cfg_thresh = 3'd3;
    pulse(10, 64'h0001_0000_0000_0001);
    for (int c = 11; c <= 40; c++) begin
      run_to(c);
      check("t3_none", OW'(m_axis_tvalid), OW'(0));
    end
    cfg_thresh = 3'd0;
    exp_q.push_back({64'd50, 64'h8000});
    pulse(45, 64'h8000);
    run_to(53); check("t3_pre", OW'(m_axis_tvalid), OW'(0));
    run_to(54); check("t3_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(56); check("t3_drained", OW'(exp_q.size()), OW'(0));
    check("t3_lost", OW'(sts_lost), OW'(0));

    // Backpressure for 20 SEND cycles with continuous hits at the tap
    do_reset(2);
    cfg_thresh    = 3'd1;
    m_axis_tready = 1'b0;
    exp_q.push_back({64'd15, 64'h4});
    pulse(10, 64'h4);
    run_to(14);
    det_data = 64'h8000_0000_0000_0000;
    run_to(19); check("t4_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(34);
    det_data = '0;
    run_to(39);
    check("t4_lost", OW'(sts_lost), OW'(LOST_ON ? 20 : 0));
    check("t4_still_valid", OW'(m_axis_tvalid), OW'(1));
    m_axis_tready = 1'b1;
    run_to(40); check("t4_released", OW'(m_axis_tvalid), OW'(0));
    check("t4_drained", OW'(exp_q.size()), OW'(0));

    // Dead time of 8: hits tapping during DEAD are dropped, first IDLE tap fires
    do_reset(2);
    cfg_dead = 16'd8;
    exp_q.push_back({64'd15, 64'h1});
    pulse(10, 64'h1);
    pulse(18, 64'h1_0000);
    pulse(22, 64'h4);
    exp_q.push_back({64'd28, 64'h2});
    pulse(23, 64'h2);
    for (int c = 24; c <= 31; c++) begin
      run_to(c);
      check("t5_dead_quiet", OW'(m_axis_tvalid), OW'(0));
    end
    check("t5_lost", OW'(sts_lost), OW'(LOST_ON ? 2 : 0));
    run_to(32); check("t5_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(33); check("t5_single", OW'(m_axis_tvalid), OW'(0));
    check("t5_drained", OW'(exp_q.size()), OW'(0));

    // Reset during ACCUM discards the event and restarts the time counter
    do_reset(2);
    cfg_dead   = 16'd0;
    cfg_window = 4'd3;
    pulse(10, 64'h1);
    run_to(17);
    do_reset(1);
    check("t6_rst_tvalid", OW'(m_axis_tvalid), OW'(0));
    check("t6_rst_lost", OW'(sts_lost), OW'(0));
    check("t6_rst_tdata", m_axis_tdata, OW'(0));
    exp_q.push_back({64'd15, 64'h10});
    pulse(10, 64'h10);
    run_to(21); check("t6_pre", OW'(m_axis_tvalid), OW'(0));
    run_to(22); check("t6_valid", OW'(m_axis_tvalid), OW'(1));
    run_to(24); check("t6_drained", OW'(exp_q.size()), OW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_coincidence_reader.md
Name: axis_coincidence_reader

Overview:
Parametrised detector-coincidence reader, successor to the fixed 64-bit/4-group reader.
- Delays raw detector hit words through a configurable pipeline, then ORs hits over a runtime-configurable window.
- Counts how many channel groups fired and emits one AXI4-Stream event (trigger timestamp plus accumulated hit word) when the count reaches a runtime threshold.
- Adds a runtime dead time after each event and a lost-activity counter.
- Sits between the detector front-end capture and the event DMA/FIFO.

Parameters:
GROUP_WIDTH, 16, channels per group
GROUP_COUNT, 4, number of groups; DW = GROUP_WIDTH*GROUP_COUNT
DELAY, 5, detector pipeline depth in stages (>=1)
WINDOW_WIDTH, 4, width of the window counter and cfg_window
DEAD_WIDTH, 16, width of the dead-time counter and cfg_dead
TIME_WIDTH, 64, timestamp width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
det_data  in  DW  raw detector hits, one bit per channel
cfg_window  in  WINDOW_WIDTH  extra accumulation samples after the trigger
cfg_thresh  in  $clog2(GROUP_COUNT+1)  minimum number of fired groups
cfg_dead  in  DEAD_WIDTH  dead-time cycles after each event
sts_lost  out  32  saturating count of blocked active samples
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  TIME_WIDTH+DW  {timestamp, hit word}
m_axis_tvalid  out  1  event valid

Behaviour:
- Reset: aclk domain; aresetn synchronous, active-low. Reset clears all pipeline stages, the accumulator, the timestamp and free-running time counters, the lost counter and all state to 0; state returns to IDLE. Reset mid-event discards the event with no partial output.
- Reset values of outputs: m_axis_tvalid=0, m_axis_tdata=0, sts_lost=0.
- Time counter: increments by 1 every cycle after reset and wraps modulo 2^TIME_WIDTH.
- Pipeline: stage0 <= det_data; stage k <= stage k-1. The tap is stage DELAY-1, so det_data reaches the tap DELAY cycles later.
- IDLE:
  - If the tap is non-zero: acc <= tap, ts <= time counter, win <= cfg_window, cntr <= 0.
  - Go to ACCUM if cfg_window != 0, else go to OR.
- ACCUM: acc <= acc | tap; cntr++. When cntr == win-1, go to OR. Total accumulated samples = cfg_window+1.
- OR: hit[g] <= |acc[g*GROUP_WIDTH +: GROUP_WIDTH] for each group g.
- SUM: sum <= popcount(hit). sum width is $clog2(GROUP_COUNT+1), so it never overflows.
- CMP:
  - If sum >= cfg_thresh: tvalid <= 1, go to SEND. cfg_thresh=0 always passes.
  - Else: go to DEAD if cfg_dead != 0, else go to IDLE. No output in either case.
- SEND:
  - tdata = {ts, acc}, held stable while tvalid=1.
  - On tready&tvalid: tvalid <= 0; go to DEAD if cfg_dead != 0, else go to IDLE.
  - tvalid never drops without a handshake.
- DEAD:
  - On entry: dcnt <= cfg_dead-1.
  - Decrement each cycle; when dcnt == 0, go to IDLE. DEAD therefore lasts exactly cfg_dead cycles.
- Back-to-back events: minimum event spacing with cfg_window=0, cfg_dead=0 and tready held high is 5 cycles (IDLE, OR, SUM, CMP, SEND).
- Configuration sampling: cfg_window is latched at trigger, cfg_thresh is sampled in CMP, cfg_dead is sampled on DEAD entry. Changing any of them mid-event does not disturb the event in progress.
- Tap activity outside IDLE/ACCUM is ignored for event building.

Optional Feature:
AXIS_COINCIDENCE_READER_LOST_EN.
- Defined: sts_lost increments by 1 on every cycle where the state is OR, SUM, CMP, SEND or DEAD and the tap is non-zero. It saturates at 2^32-1.
- Undefined: sts_lost is tied to 0 and no counter logic is generated.

Decomposition:
- Package axis_coincidence_pkg: state enum (IDLE, ACCUM, OR, SUM, CMP, SEND, DEAD) in 3 bits, plus a localparam function for popcount width.
- One sub-module, coincidence_popcount: combinational group-OR plus popcount, parametrised by GROUP_WIDTH and GROUP_COUNT. Used by the OR and SUM stages through registers in the parent.

Test Plan:
- Defaults, cfg_window=0, cfg_thresh=2, cfg_dead=0, tready=1. det_data=64'h0001_0000_0000_0001 at cycle 10 -> tvalid at cycle 19 with tdata[63:0]=64'h0001_0000_0000_0001 and timestamp=15; single beat.
- cfg_window=3: hits 64'h1 at cycle 10 and 64'h1_0000 at cycle 13 -> one event with hit word 64'h1_0001. A hit at cycle 14 is excluded.
- cfg_thresh=3, two groups hit -> no tvalid ever. cfg_thresh=0 with a single channel hit -> event emitted.
- tready=0 for 20 cycles during SEND -> tdata/tvalid stable throughout; with LOST_EN, continuous hits meanwhile give sts_lost=20; handshake completes on tready=1.
- cfg_dead=8: second hit arriving during the dead time -> no second event. A hit 8 cycles after the handshake -> event.
- aresetn=0 for 1 cycle during ACCUM -> tvalid=0, sts_lost=0, time counter restarts from 0; next hit produces a fresh event.
